// File: rtl/gibbs_pkg.sv
// Shared types and helpers for the checkerboard Gibbs sweep controller.
// The colour mask is built once at elaboration time from the grid geometry.
package gibbs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_PHASE_A = 3'd2,
        ST_PHASE_B = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_HOLD    = 3'd5,
        ST_DONE    = 3'd6
    } sweep_state_t;

    // Upper bound on grid size the mask helper can describe; callers slice [N-1:0].
    localparam int MASK_MAX_W = 1024;

    // parity 0 selects nodes with (r+c) even, parity 1 selects (r+c) odd.
    function automatic logic [MASK_MAX_W-1:0] checker_mask(
        input int   rows,
        input int   cols,
        input logic parity
    );
        logic [MASK_MAX_W-1:0] mask;
        mask = '0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                if ((((r + c) % 2) == 1) == parity) begin
                    mask = mask | (MASK_MAX_W'(1) << (r * cols + c));
                end
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/gibbs_sweep_ctrl_settle_counter.sv
// Loadable down-counter timing one colour phase; last flags the final cycle.
// Loaded to SETTLE_CYCLES-1 on phase entry, so a phase lasts exactly SETTLE_CYCLES cycles.
module settle_counter #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic last
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = LOAD_VAL;
        end else if (dec && (count_reg != '0)) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= LOAD_VAL;
        end else begin
            count_reg <= count_next;
        end
    end

    assign last = (count_reg == '0);

endmodule

// File: rtl/gibbs_sweep_ctrl.sv
// Checkerboard Gibbs sweep sequencer: clears the grid, alternates colour updates,
// burns in, then hands out node snapshots over a valid/ready handshake.
module gibbs_sweep_ctrl
    import gibbs_pkg::*;
#(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [CNT_W-1:0]       burn_in,
    input  logic [CNT_W-1:0]       num_samples,
    input  logic [ROWS*COLS-1:0]   node_state,
    output logic                   node_on,
    output logic [ROWS*COLS-1:0]   update_en,
    output logic                   busy,
    output logic                   sample_valid,
    input  logic                   sample_ready,
    output logic [ROWS*COLS-1:0]   sample_data,
    output logic [CNT_W-1:0]       sample_idx,
    output logic                   done
);

    localparam int N = ROWS * COLS;

    localparam logic [MASK_MAX_W-1:0] EVEN_FULL = checker_mask(ROWS, COLS, 1'b0);
    localparam logic [MASK_MAX_W-1:0] ODD_FULL  = checker_mask(ROWS, COLS, 1'b1);
    localparam logic [N-1:0]          EVEN_MASK = EVEN_FULL[N-1:0];
    localparam logic [N-1:0]          ODD_MASK  = ODD_FULL[N-1:0];

    sweep_state_t     state_reg,     state_next;
    logic [CNT_W-1:0] burn_reg,      burn_next;
    logic [CNT_W-1:0] nsamp_reg,     nsamp_next;
    logic [CNT_W-1:0] sweep_cnt_reg, sweep_cnt_next;
    logic [CNT_W-1:0] idx_reg,       idx_next;
    logic             burn_done_reg, burn_done_next;
    logic [N-1:0]     data_reg,      data_next;

    logic             in_phase;
    logic             phase_last;
    logic             phase_a_fire;
    logic             phase_b_fire;
    logic [CNT_W-1:0] idx_inc;

    assign in_phase = (state_reg == ST_PHASE_A) || (state_reg == ST_PHASE_B);
    assign idx_inc  = idx_reg + CNT_W'(1);

    // One counter serves both colours: it reloads on every phase boundary.
    settle_counter #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .clk  (clk),
        .rst  (rst),
        .load (!in_phase || phase_last),
        .dec  (in_phase),
        .last (phase_last)
    );

    always_comb begin
        state_next     = state_reg;
        burn_next      = burn_reg;
        nsamp_next     = nsamp_reg;
        sweep_cnt_next = sweep_cnt_reg;
        idx_next       = idx_reg;
        burn_done_next = burn_done_reg;
        data_next      = data_reg;

        if (abort && (state_reg != ST_IDLE)) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start && (num_samples != '0)) begin
                        burn_next      = burn_in;
                        nsamp_next     = num_samples;
                        sweep_cnt_next = '0;
                        idx_next       = '0;
                        burn_done_next = 1'b0;
                        state_next     = ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    state_next = ST_PHASE_A;
                end
                ST_PHASE_A: begin
                    if (phase_last) begin
                        state_next = ST_PHASE_B;
                    end
                end
                ST_PHASE_B: begin
                    if (phase_last) begin
                        if (burn_done_reg) begin
                            // Thinning of one sweep once sampling has begun.
                            state_next = ST_CAPTURE;
                        end else begin
                            sweep_cnt_next = sweep_cnt_reg + CNT_W'(1);
                            if (sweep_cnt_reg == burn_reg) begin
                                burn_done_next = 1'b1;
                                state_next     = ST_CAPTURE;
                            end else begin
                                state_next = ST_PHASE_A;
                            end
                        end
                    end
                end
                ST_CAPTURE: begin
                    data_next  = node_state;
                    state_next = ST_HOLD;
                end
                ST_HOLD: begin
                    if (sample_ready) begin
                        idx_next   = idx_inc;
                        state_next = (idx_inc == nsamp_reg) ? ST_DONE : ST_PHASE_A;
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            burn_reg      <= '0;
            nsamp_reg     <= '0;
            sweep_cnt_reg <= '0;
            idx_reg       <= '0;
            burn_done_reg <= 1'b0;
            data_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            burn_reg      <= burn_next;
            nsamp_reg     <= nsamp_next;
            sweep_cnt_reg <= sweep_cnt_next;
            idx_reg       <= idx_next;
            burn_done_reg <= burn_done_next;
            data_reg      <= data_next;
        end
    end

    // Enables decode from registered state only, so masks can never overlap.
    assign phase_a_fire = (state_reg == ST_PHASE_A) && phase_last;
    assign phase_b_fire = (state_reg == ST_PHASE_B) && phase_last;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_update
            assign update_en[gi] = (phase_a_fire && EVEN_MASK[gi]) ||
                                   (phase_b_fire && ODD_MASK[gi]);
        end
    endgenerate

    assign node_on      = (state_reg != ST_IDLE) && (state_reg != ST_CLEAR);
    assign busy         = (state_reg != ST_IDLE);
    assign sample_valid = (state_reg == ST_HOLD);
    assign done         = (state_reg == ST_DONE);
    assign sample_data  = data_reg;
    assign sample_idx   = idx_reg;

endmodule

// File: tb/tb_gibbs_sweep_ctrl.sv
// Directed-vector bench for gibbs_sweep_ctrl on a 4x4 grid with two-cycle phases.
module tb_gibbs_sweep_ctrl;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int S      = 2;
    localparam int CNT_W  = 16;
    localparam int N      = ROWS * COLS;
    localparam int BUDGET = 400;

    localparam logic [15:0] EVEN_M = 16'hA5A5;
    localparam logic [15:0] ODD_M  = 16'h5A5A;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] burn_in;
    logic [CNT_W-1:0] num_samples;
    logic [N-1:0]     node_state;
    logic             node_on;
    logic [N-1:0]     update_en;
    logic             busy;
    logic             sample_valid;
    logic             sample_ready;
    logic [N-1:0]     sample_data;
    logic [CNT_W-1:0] sample_idx;
    logic             done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] burn;
        logic [15:0] nsamp;
        int          stall_idx;
        int          stall_len;
        bit          noisy;
        int          exp_valid;
        int          exp_pulses;
        int          exp_done;
    } vec_t;

    vec_t vecs[6];
    vec_t restart_vec;

    gibbs_sweep_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(S), .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .burn_in      (burn_in),
        .num_samples  (num_samples),
        .node_state   (node_state),
        .node_on      (node_on),
        .update_en    (update_en),
        .busy         (busy),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_data  (sample_data),
        .sample_idx   (sample_idx),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mk(input int k);
        return 16'(k * 977) ^ 16'hC3A5;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Runs one full start..done sequence; cycle k is observed k ticks after start is applied.
    task automatic run_vec(input vec_t v);
        int          pulses;
        int          first_valid;
        int          done_cyc;
        int          exp_idx;
        int          stall_left;
        bit          exp_even;
        bit          in_hold;
        bit          finished;
        logic [15:0] held;
        pulses      = 0;
        first_valid = -1;
        done_cyc    = -1;
        exp_idx     = 0;
        stall_left  = v.stall_len;
        exp_even    = 1'b1;
        in_hold     = 1'b0;
        finished    = 1'b0;
        held        = '0;
        burn_in      = v.burn;
        num_samples  = v.nsamp;
        start        = 1'b1;
        sample_ready = 1'b1;
        node_state   = mk(0);
        for (int k = 1; k <= BUDGET && !finished; k++) begin
            tick();
            node_state = mk(k);
            if (v.noisy) begin
                start       = 1'b1;
                burn_in     = 16'($urandom);
                num_samples = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            if (k == 1) begin
                check("clear_node_on", 32'(node_on), 32'd0);
                check("clear_busy", 32'(busy), 32'd1);
            end
            if (k == 2) check("phase_node_on", 32'(node_on), 32'd1);
            if (update_en != '0) begin
                check("mask", 32'(update_en), 32'(exp_even ? EVEN_M : ODD_M));
                exp_even = !exp_even;
                if (first_valid < 0) pulses++;
            end
            if (sample_valid) begin
                if (!in_hold) begin
                    in_hold = 1'b1;
                    held    = mk(k - 1);
                    if (first_valid < 0) first_valid = k;
                    $display("sample idx=%0d data=%h cycle=%0d", sample_idx, sample_data, k);
                end
                check("hold_data", 32'(sample_data), 32'(held));
                check("hold_idx", 32'(sample_idx), 32'(exp_idx));
                check("hold_frozen", 32'(update_en), 32'd0);
                if ((exp_idx == v.stall_idx) && (stall_left > 0)) begin
                    sample_ready = 1'b0;
                    stall_left--;
                end else begin
                    sample_ready = 1'b1;
                    in_hold      = 1'b0;
                    exp_idx++;
                end
            end else begin
                sample_ready = 1'b1;
            end
            if (done) begin
                done_cyc = k;
                finished = 1'b1;
            end
        end
        start = 1'b0;
        if (!finished) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: no done within %0d cycles (burn=%0d nsamp=%0d)", BUDGET, v.burn, v.nsamp);
        end
        check("first_valid_cycle", 32'(first_valid), 32'(v.exp_valid));
        check("pulses_before_valid", 32'(pulses), 32'(v.exp_pulses));
        check("done_cycle", 32'(done_cyc), 32'(v.exp_done));
        check("samples_emitted", 32'(exp_idx), 32'(v.nsamp));
        tick();
        check("done_single_pulse", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        //          burn   nsamp  stall_idx len noisy valid pulses done
        vecs[0] = '{16'd0, 16'd1, -1,       0,  1'b0, 7,    2,     8};
        vecs[1] = '{16'd3, 16'd1, -1,       0,  1'b0, 19,   8,     20};
        vecs[2] = '{16'd1, 16'd2, -1,       0,  1'b1, 11,   4,     18};
        vecs[3] = '{16'd0, 16'd3, 1,        5,  1'b0, 7,    2,     25};
        vecs[4] = '{16'd2, 16'd1, -1,       0,  1'b1, 15,   6,     16};
        vecs[5] = '{16'd0, 16'd2, 0,        2,  1'b0, 7,    2,     16};
        restart_vec = '{16'd1, 16'd1, -1,   0,  1'b0, 11,   4,     12};

        rst          = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        burn_in      = '0;
        num_samples  = '0;
        node_state   = '0;
        sample_ready = 1'b1;

        #22;
        check("rst_node_on", 32'(node_on), 32'd0);
        check("rst_update_en", 32'(update_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_data", 32'(sample_data), 32'd0);
        check("rst_idx", 32'(sample_idx), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Abort in the second sweep's odd phase, then restart cleanly.
        burn_in     = 16'd1;
        num_samples = 16'd1;
        start       = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            start = 1'b0;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_update_en", 32'(update_en), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_node_on", 32'(node_on), 32'd0);
        check("abort_valid", 32'(sample_valid), 32'd0);
        tick();
        check("abort_no_late_done", 32'(done), 32'd0);
        run_vec(restart_vec);

        // Zero-sample start must be ignored.
        num_samples = 16'd0;
        burn_in     = 16'd0;
        start       = 1'b1;
        tick();
        check("zero_start_busy", 32'(busy), 32'd0);
        tick();
        check("zero_start_busy2", 32'(busy), 32'd0);
        check("zero_start_node_on", 32'(node_on), 32'd0);
        start = 1'b0;

        // Asynchronous reset while a snapshot waits in HOLD.
        burn_in      = 16'd0;
        num_samples  = 16'd2;
        sample_ready = 1'b0;
        start        = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            start = 1'b0;
        end
        check("pre_rst_valid", 32'(sample_valid), 32'd1);
        check("pre_rst_node_on", 32'(node_on), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(sample_valid), 32'd0);
        check("async_rst_node_on", 32'(node_on), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst          = 1'b0;
        sample_ready = 1'b1;
        tick();
        check("rst_release_busy", 32'(busy), 32'd0);
        check("rst_release_data", 32'(sample_data), 32'd0);
        check("rst_release_idx", 32'(sample_idx), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
